// File: rtl/issue_scheduler.sv
// Dual-issue in-order scheduler: picks 0/1/2 head instructions per cycle, with a per-register load-use scoreboard.
// Latency: freeze/dependency controls are combinational; issue lanes are registered (1 cycle). ex_stall holds lanes and scoreboard.
module issue_scheduler #(
    parameter int LOAD_LATENCY = 3
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] instruction0,
    input  logic [31:0] instruction1,
    input  logic        nothing_filled,
    input  logic        ex_stall,
    output logic        freeze1,
    output logic        freeze2,
    output logic        dependency_on_ins2,
    output logic        issue0_valid,
    output logic [31:0] issue0_instr,
    output logic        issue1_valid,
    output logic [31:0] issue1_instr
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    function automatic logic uses_rs1(input logic [31:0] i);
        return !(i[6:0] == OP_LUI || i[6:0] == OP_AUIPC || i[6:0] == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [31:0] i);
        return i[6:0] == OP_OP || i[6:0] == OP_STORE || i[6:0] == OP_BRANCH;
    endfunction

    // x0 destinations never create hazards, so they count as "not writing".
    function automatic logic writes_rd(input logic [31:0] i);
        return !(i[6:0] == OP_STORE || i[6:0] == OP_BRANCH) && i[11:7] != 5'd0;
    endfunction

    function automatic logic is_mem(input logic [31:0] i);
        return i[6:0] == OP_LOAD || i[6:0] == OP_STORE;
    endfunction

    function automatic logic is_ctrl(input logic [31:0] i);
        return i[6:0] == OP_BRANCH || i[6:0] == OP_JAL || i[6:0] == OP_JALR;
    endfunction

    logic [31:0][1:0] cnt;
    logic             has0, has1, hz0, sb1, raw, waw, pair_block, can0, can1;
    logic [4:0]       rd0;

    always_comb begin
        rd0  = instruction0[11:7];
        has0 = instruction0 != 32'd0;
        has1 = instruction1 != 32'd0;
        hz0  = (uses_rs1(instruction0) && cnt[instruction0[19:15]] != 2'd0) ||
               (uses_rs2(instruction0) && cnt[instruction0[24:20]] != 2'd0);
        sb1  = (uses_rs1(instruction1) && cnt[instruction1[19:15]] != 2'd0) ||
               (uses_rs2(instruction1) && cnt[instruction1[24:20]] != 2'd0);
        raw  = writes_rd(instruction0) &&
               ((uses_rs1(instruction1) && instruction1[19:15] == rd0) ||
                (uses_rs2(instruction1) && instruction1[24:20] == rd0));
        waw  = writes_rd(instruction0) && writes_rd(instruction1) && instruction1[11:7] == rd0;
        pair_block = raw || waw || (is_mem(instruction0) && is_mem(instruction1)) ||
                     is_ctrl(instruction0) || is_ctrl(instruction1);
        // Folding n_rst in here forces the buffer controls to their idle values during reset.
        can0 = n_rst && !nothing_filled && has0 && !ex_stall && !hz0;
        can1 = can0 && has1 && !sb1 && !pair_block;
        freeze1            = !can0;
        dependency_on_ins2 = can0 && has1 && !can1;
        freeze2            = n_rst && has1 && sb1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (!ex_stall) begin
            for (int r = 0; r < 32; r++) begin
                if (cnt[r] != 2'd0) cnt[r] <= cnt[r] - 2'd1;
            end
            // Memory ops never pair, so only slot 0 can carry a load.
            if (can0 && instruction0[6:0] == OP_LOAD && rd0 != 5'd0)
                cnt[rd0] <= 2'(LOAD_LATENCY - 1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            issue0_valid <= 1'b0;
            issue0_instr <= 32'd0;
            issue1_valid <= 1'b0;
            issue1_instr <= 32'd0;
        end else if (!ex_stall) begin
            issue0_valid <= can0;
            issue0_instr <= can0 ? instruction0 : 32'd0;
            issue1_valid <= can1;
            issue1_instr <= can1 ? instruction1 : 32'd0;
        end
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed scenarios plus a randomized fetch-buffer stream
// compared against a model that tracks, per register, the issue edge from which it may be read.
module tb_issue_scheduler;
    localparam int LAT = 3;

    localparam logic [31:0] ADDI1 = 32'h00100093;
    localparam logic [31:0] ADDI2 = 32'h00200113;
    localparam logic [31:0] ADD3  = 32'h001081B3;
    localparam logic [31:0] LW5   = 32'h00002283;
    localparam logic [31:0] ADD6  = 32'h00028333;
    localparam logic [31:0] SW1   = 32'h00102023;
    localparam logic [31:0] BEQ   = 32'h00000063;
    localparam logic [31:0] JAL0  = 32'h0000006F;

    logic        clk, n_rst, nothing_filled, ex_stall;
    logic [31:0] instruction0, instruction1, issue0_instr, issue1_instr;
    logic        freeze1, freeze2, dependency_on_ins2, issue0_valid, issue1_valid;

    issue_scheduler #(.LOAD_LATENCY(LAT)) dut (
        .clk(clk), .n_rst(n_rst), .instruction0(instruction0), .instruction1(instruction1),
        .nothing_filled(nothing_filled), .ex_stall(ex_stall), .freeze1(freeze1), .freeze2(freeze2),
        .dependency_on_ins2(dependency_on_ins2), .issue0_valid(issue0_valid), .issue0_instr(issue0_instr),
        .issue1_valid(issue1_valid), .issue1_instr(issue1_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: ready_at[r] = first issue edge number at which r may be read.
    int          ready_at [32];
    int          nedge = 0;
    logic        exp_v0, exp_v1;
    logic [31:0] exp_i0, exp_i1;
    logic        last_can0, last_can1, s_f1, s_f2, s_dep;
    logic [31:0] q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void decode(input logic [31:0] w, output bit r1, output bit r2,
                                   output bit wr, output bit mem, output bit ctl, output bit ld);
        r1 = 1; r2 = 0; wr = 1; mem = 0; ctl = 0; ld = 0;
        case (w[6:0])
            7'h37, 7'h17: r1 = 0;
            7'h6F:        begin r1 = 0; ctl = 1; end
            7'h67:        ctl = 1;
            7'h63:        begin r2 = 1; wr = 0; ctl = 1; end
            7'h03:        begin mem = 1; ld = 1; end
            7'h23:        begin r2 = 1; wr = 0; mem = 1; end
            7'h33:        r2 = 1;
            default:      ;
        endcase
        if (w[11:7] == 5'd0) wr = 0;
    endfunction

    function automatic bit busy(input logic [4:0] r);
        return ready_at[r] > nedge + 1;
    endfunction

    // Called at posedge+1; drives heads, checks controls at mid-cycle and lanes after the edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic nf, input logic st);
        bit r1a, r2a, wra, mema, ctla, lda, r1b, r2b, wrb, memb, ctlb, ldb;
        bit hz0, sb1, blk, c0, c1;
        instruction0 = a; instruction1 = b; nothing_filled = nf; ex_stall = st;
        #4;
        decode(a, r1a, r2a, wra, mema, ctla, lda);
        decode(b, r1b, r2b, wrb, memb, ctlb, ldb);
        hz0 = (r1a && busy(a[19:15])) || (r2a && busy(a[24:20]));
        sb1 = (r1b && busy(b[19:15])) || (r2b && busy(b[24:20]));
        blk = (wra && ((r1b && b[19:15] == a[11:7]) || (r2b && b[24:20] == a[11:7]))) ||
              (wra && wrb && a[11:7] == b[11:7]) || (mema && memb) || ctla || ctlb;
        c0 = !nf && a != 0 && !st && !hz0;
        c1 = c0 && b != 0 && !sb1 && !blk;
        s_f1 = freeze1; s_f2 = freeze2; s_dep = dependency_on_ins2;
        check("freeze1", freeze1, !c0);
        check("freeze2", freeze2, b != 0 && sb1);
        check("dep_ins2", dependency_on_ins2, c0 && b != 0 && !c1);
        last_can0 = c0; last_can1 = c1;
        if (!st) begin
            exp_v0 = c0; exp_i0 = c0 ? a : 32'd0;
            exp_v1 = c1; exp_i1 = c1 ? b : 32'd0;
            nedge++;
            if (c0 && lda && a[11:7] != 5'd0) ready_at[a[11:7]] = nedge + LAT;
        end
        @(posedge clk); #1;
        check("issue0_valid", issue0_valid, exp_v0);
        check("issue0_instr", issue0_instr, exp_i0);
        check("issue1_valid", issue1_valid, exp_v1);
        check("issue1_instr", issue1_instr, exp_i1);
    endtask

    // Called at posedge+1: asserts reset mid-cycle with live heads, releases it at the negedge.
    task automatic do_reset();
        #1 n_rst = 1'b0;
        #1;
        check("rst_v0", issue0_valid, 0);
        check("rst_i0", issue0_instr, 0);
        check("rst_v1", issue1_valid, 0);
        check("rst_i1", issue1_instr, 0);
        check("rst_freeze1", freeze1, 1);
        check("rst_freeze2", freeze2, 0);
        check("rst_dep", dependency_on_ins2, 0);
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        exp_v0 = 0; exp_v1 = 0; exp_i0 = 0; exp_i1 = 0;
        @(negedge clk);
        n_rst = 1'b1; instruction0 = 0; instruction1 = 0; nothing_filled = 1; ex_stall = 0;
        @(posedge clk); #1;
        nedge++;
        check("post_rst_v0", issue0_valid, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h03, 7'h23, 7'h13, 7'h33};
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        logic [31:0] a, b;
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        exp_v0 = 0; exp_v1 = 0; exp_i0 = 0; exp_i1 = 0;
        n_rst = 1'b0; instruction0 = ADDI1; instruction1 = LW5; nothing_filled = 0; ex_stall = 0;
        #3;
        check("init_freeze1", freeze1, 1);
        check("init_freeze2", freeze2, 0);
        check("init_dep", dependency_on_ins2, 0);
        check("init_v0", issue0_valid, 0);
        check("init_v1", issue1_valid, 0);
        @(negedge clk);
        n_rst = 1'b1; instruction0 = 0; instruction1 = 0; nothing_filled = 1;
        @(posedge clk); #1;
        nedge++;

        step(ADDI1, ADDI2, 0, 0);
        check("pair_f1", s_f1, 0); check("pair_dep", s_dep, 0);
        check("pair_v1", issue1_valid, 1); check("pair_i1", issue1_instr, ADDI2);
        step(ADDI1, ADD3, 0, 0);
        check("raw_dep", s_dep, 1); check("raw_f2", s_f2, 0); check("raw_v1", issue1_valid, 0);

        step(LW5, ADD6, 0, 0);
        check("lu_dep", s_dep, 1);
        step(ADD6, 0, 0, 0); check("lu_stall_a", s_f1, 1);
        step(ADD6, 0, 0, 0); check("lu_stall_b", s_f1, 1);
        step(ADD6, 0, 0, 0); check("lu_go", s_f1, 0); check("lu_issue", issue0_instr, ADD6);

        step(LW5, SW1, 0, 0); check("mem_pair_dep", s_dep, 1);
        step(BEQ, ADDI1, 0, 0); check("br0_dep", s_dep, 1);
        step(ADDI1, JAL0, 0, 0); check("jal1_dep", s_dep, 1);

        step(LW5, 0, 0, 0);
        step(ADD6, 0, 0, 1); check("stl_f1_a", s_f1, 1); check("stl_hold_a", issue0_instr, LW5);
        step(ADD6, 0, 0, 1); check("stl_f1_b", s_f1, 1); check("stl_hold_b", issue0_valid, 1);
        step(ADD6, 0, 0, 0); check("stl_cnt_a", s_f1, 1);
        step(ADD6, 0, 0, 0); check("stl_cnt_b", s_f1, 1);
        step(ADD6, 0, 0, 0); check("stl_resume", s_f1, 0);

        step(LW5, ADDI1, 0, 0); check("mid_both", issue1_valid, 1);
        instruction0 = ADD6; instruction1 = ADD3; nothing_filled = 0;
        do_reset();
        step(ADD6, 0, 0, 0); check("rst_clears_sb", s_f1, 0); check("rst_issue", issue0_valid, 1);

        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) != 0)
                while (q.size() < 4) q.push_back(rand_instr());
            a = (q.size() > 0) ? q[0] : 32'd0;
            b = (q.size() > 1) ? q[1] : 32'd0;
            step(a, b, q.size() == 0 || $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
            if (last_can0 && q.size() > 0) void'(q.pop_front());
            if (last_can1 && q.size() > 0) void'(q.pop_front());
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Dual-issue scheduler sitting directly downstream of the instruction fetch buffer. Each cycle it inspects the buffer's two head instructions (`instruction0`, `instruction1`) and decides whether to issue both, only the first, or neither. It drives the buffer's `freeze1`, `freeze2` and `dependency_on_ins2` controls so the buffer slides by 2, 1 or 0 entries. A per-register load scoreboard enforces load-use latency. Issued instructions are registered towards the two execute lanes.

## Interface
Parameters:
- `LOAD_LATENCY`, default 3: minimum number of issue edges between a load and its first consumer; legal range 1..3.

Ports:
- `clk`  in  1  system clock, rising edge
- `n_rst`  in  1  asynchronous active-low reset
- `instruction0`  in  32  buffer head (oldest); 32'h0 means empty
- `instruction1`  in  32  buffer head+1; 32'h0 means empty
- `nothing_filled`  in  1  buffer empty; nothing may issue
- `ex_stall`  in  1  execute lanes not accepting this cycle
- `freeze1`  out  1  slot 0 not issuing; buffer must not slide
- `freeze2`  out  1  slot 1 blocked by a scoreboard (pending load) hazard
- `dependency_on_ins2`  out  1  slot 0 issues, slot 1 held; buffer slides by 1
- `issue0_valid`  out  1  lane 0 holds a valid instruction
- `issue0_instr`  out  32  lane 0 instruction
- `issue1_valid`  out  1  lane 1 holds a valid instruction
- `issue1_instr`  out  32  lane 1 instruction

## Operation
- Decode follows RV32I:
  - `rd` = [11:7], `rs1` = [19:15], `rs2` = [24:20], opcode = [6:0].
  - Uses `rs1`: every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - Uses `rs2`: R-type (0110011), store (0100011), branch (1100011).
  - Writes `rd`: every opcode except store and branch. Writes with `rd` = x0 are ignored for all hazard checks.
  - Load = 0000011. Memory op = load or store. Control = branch, JAL, JALR (1100111).
- Scoreboard: 32 counters `cnt[r]`, 2 bits each. A register is pending when `cnt[r]` != 0.
- `can0` = !`nothing_filled` && `instruction0` != 0 && !`ex_stall` && no source of `instruction0` pending.
- `sb1` = a source of `instruction1` is pending.
- `pair_block` is true if any of the following hold:
  - `instruction1` reads the `rd` of `instruction0` (RAW);
  - both instructions write the same nonzero `rd` (WAW);
  - both are memory ops;
  - `instruction0` is a control op;
  - `instruction1` is a control op.
- `can1` = `can0` && `instruction1` != 0 && !`sb1` && !`pair_block`.
- Combinational outputs:
  - `freeze1` = !`can0`
  - `dependency_on_ins2` = `can0` && `instruction1` != 0 && !`can1`
  - `freeze2` = `instruction1` != 0 && `sb1`
- `instruction1` == 0 with `can0` true: slot 0 issues alone, `dependency_on_ins2` = 0, and the buffer slides by 2.
- Issue registers, on each rising edge:
  - If `ex_stall`: hold all four issue outputs.
  - Else: `issue0_valid` <= `can0`, `issue0_instr` <= `can0` ? `instruction0` : 0; `issue1_valid` <= `can1`, `issue1_instr` <= `can1` ? `instruction1` : 0.
- Scoreboard update, on each edge when !`ex_stall`:
  - Every nonzero counter decrements by 1.
  - A load issuing with `rd` != 0 sets `cnt[rd]` <= `LOAD_LATENCY`-1. This set overrides a decrement of the same entry.
  - At most one load issues per edge, because memory ops never dual-issue.
- While `ex_stall` = 1, all counters hold.

## Timing
- Reset (`n_rst` low, asynchronous):
  - `issue0_valid` = `issue1_valid` = 0; `issue0_instr` = `issue1_instr` = 0.
  - All `cnt` = 0.
  - `freeze1` = 1, `freeze2` = 0, `dependency_on_ins2` = 0, all forced during reset.
- Reset release takes effect at the first rising edge with `n_rst` high. Deasserting reset mid-operation discards all pending scoreboard state.
- `freeze1`, `freeze2` and `dependency_on_ins2` are combinational, valid in the same cycle as `instruction0`/`instruction1`, and sampled by the buffer on the same edge.
- Issue latency: 1 cycle from the head instruction appearing to `issueN_valid`.
- Load-use:
  - A load issued at edge E lets its consumer issue no earlier than edge E+`LOAD_LATENCY` (ignoring `ex_stall` edges).
  - `LOAD_LATENCY` = 1 allows back-to-back issue on consecutive edges.
- Ordering is always in order: slot 1 never issues without slot 0.

## Test plan
- Independent pair: `addi x1,x0,1` and `addi x2,x0,2` at the head -> `freeze1` = 0, `dependency_on_ins2` = 0; next cycle both valid with the matching words.
- Intra-pair RAW: `addi x1,x0,1` then `add x3,x1,x1` -> `dependency_on_ins2` = 1, `freeze2` = 0; only `issue0_valid` = 1 next cycle.
- Load-use, `LOAD_LATENCY` = 3: `lw x5,0(x0)` issued at edge E, followed by `add x6,x5,x0` at the head -> `freeze1` = 1 for 2 cycles, and `add` issues at edge E+3.
- Structural/control: `lw` + `sw` pair -> 1 issued. `beq` in slot 0 -> `dependency_on_ins2` = 1. `jal` in slot 1 -> `dependency_on_ins2` = 1.
- `ex_stall` = 1 for 2 cycles with a pending load -> issue outputs held, `freeze1` = 1, and the counter unchanged. After release, the countdown resumes.
- Asynchronous reset asserted mid-stream with both lanes valid and `cnt[5]` = 2 -> outputs clear immediately. After release, `add x6,x5,x0` issues without stalling.
